// File: rtl/game_ctrl_fsm_v2.sv
// Memory-game control FSM: setup, FPGA playback, user entry with tick-counted
// timeout, check, round advance, retry on failure and final result.
// Moore outputs drive the datapath resets/enables; status counters feed the display.
module game_ctrl_fsm_v2 #(
  parameter int unsigned MAX_ROUNDS    = 8,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned TIMEOUT_TICKS = 5,
  parameter int unsigned ROUND_W       = $clog2(MAX_ROUNDS + 1),
  parameter int unsigned LIFE_W        = $clog2(LIVES + 1),
  parameter int unsigned TO_W          = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter,
  input  logic               tick,
  input  logic               end_fpga,
  input  logic               end_user,
  input  logic               match,
  output logic               r1,
  output logic               r2,
  output logic               e1,
  output logic               e2,
  output logic               e3,
  output logic               e4,
  output logic               sel,
  output logic               replay,
  output logic               won,
  output logic [ROUND_W-1:0] round,
  output logic [LIFE_W-1:0]  lives_left,
  output logic [TO_W-1:0]    time_left
);

  localparam logic [2:0] INIT       = 3'd0;
  localparam logic [2:0] SETUP      = 3'd1;
  localparam logic [2:0] PLAY_FPGA  = 3'd2;
  localparam logic [2:0] PLAY_USER  = 3'd3;
  localparam logic [2:0] CHECK      = 3'd4;
  localparam logic [2:0] NEXT_ROUND = 3'd5;
  localparam logic [2:0] RETRY      = 3'd6;
  localparam logic [2:0] RESULT     = 3'd7;

  localparam logic [ROUND_W-1:0] RoundMax  = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] RoundLast = ROUND_W'(MAX_ROUNDS - 1);
  localparam logic [LIFE_W-1:0]  LivesMax  = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0]  LifeOne   = LIFE_W'(1);
  localparam logic [TO_W-1:0]    TimerMax  = TO_W'(TIMEOUT_TICKS);

  logic [2:0]         r_state;
  logic [ROUND_W-1:0] r_round;
  logic [LIFE_W-1:0]  r_lives;
  logic [TO_W-1:0]    r_timer;
  logic               r_won;
  logic               r_enter_q;

  logic [2:0]         w_state_d;
  logic [ROUND_W-1:0] w_round_d;
  logic [LIFE_W-1:0]  w_lives_d;
  logic [TO_W-1:0]    w_timer_d;
  logic               w_won_d;
  logic               w_enter_p;

  assign w_enter_p = enter & ~r_enter_q;

  // Next-state and counter updates; each state only looks at the inputs it consumes.
  always_comb begin
    w_state_d = r_state;
    w_round_d = r_round;
    w_lives_d = r_lives;
    w_timer_d = r_timer;
    w_won_d   = r_won;
    case (r_state)
      INIT: begin
        w_state_d = SETUP;
        w_round_d = '0;
        w_lives_d = LivesMax;
        w_timer_d = '0;
        w_won_d   = 1'b0;
      end
      SETUP: begin
        if (w_enter_p) w_state_d = PLAY_FPGA;
      end
      PLAY_FPGA: begin
        if (end_fpga) begin
          w_state_d = PLAY_USER;
          w_timer_d = '0;
        end
      end
      PLAY_USER: begin
        // A finished entry beats expiry; a tick in a leaving cycle is dropped.
        if (end_user) begin
          w_state_d = CHECK;
        end else if (r_timer >= TimerMax) begin
          w_state_d = RETRY;
        end else if (tick) begin
          w_timer_d = r_timer + TO_W'(1);
        end
      end
      CHECK: begin
        w_state_d = match ? NEXT_ROUND : RETRY;
      end
      NEXT_ROUND: begin
        if (r_round < RoundMax) w_round_d = r_round + ROUND_W'(1);
        if (r_round >= RoundLast) begin
          w_state_d = RESULT;
          w_won_d   = 1'b1;
        end else begin
          w_state_d = PLAY_FPGA;
        end
      end
      RETRY: begin
        if (r_lives != '0) w_lives_d = r_lives - LifeOne;
        if (r_lives <= LifeOne) begin
          w_state_d = RESULT;
          w_won_d   = 1'b0;
        end else begin
          w_state_d = PLAY_FPGA;
        end
      end
      RESULT: begin
        if (w_enter_p) w_state_d = INIT;
      end
      default: w_state_d = INIT;
    endcase
  end

  // State and counter registers; synchronous reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= INIT;
      r_round   <= '0;
      r_lives   <= LivesMax;
      r_timer   <= '0;
      r_won     <= 1'b0;
      r_enter_q <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_round   <= w_round_d;
      r_lives   <= w_lives_d;
      r_timer   <= w_timer_d;
      r_won     <= w_won_d;
      r_enter_q <= enter;
    end
  end

  // Moore decode of datapath controls from the current state.
  always_comb begin
    r1     = 1'b0;
    r2     = 1'b0;
    e1     = 1'b0;
    e2     = 1'b0;
    e3     = 1'b0;
    e4     = 1'b0;
    sel    = 1'b0;
    replay = 1'b0;
    case (r_state)
      INIT: begin
        r1 = 1'b1;
        r2 = 1'b1;
      end
      SETUP:      e1     = 1'b1;
      PLAY_FPGA:  e3     = 1'b1;
      PLAY_USER:  e2     = 1'b1;
      CHECK:      e4     = 1'b1;
      NEXT_ROUND: r2     = 1'b1;
      RETRY:      replay = 1'b1;
      RESULT:     sel    = 1'b1;
      default:    ;
    endcase
  end

  assign won        = r_won;
  assign round      = r_round;
  assign lives_left = r_lives;
  assign time_left  = TimerMax - r_timer;

endmodule

// File: tb/tb_game_ctrl_fsm_v2.sv
// Directed bench for game_ctrl_fsm_v2 with MAX_ROUNDS=2, LIVES=2, TIMEOUT_TICKS=3.
module tb_game_ctrl_fsm_v2;

  localparam int unsigned MaxRounds = 2;
  localparam int unsigned Lives     = 2;
  localparam int unsigned ToTicks   = 3;
  localparam int unsigned RoundW    = $clog2(MaxRounds + 1);
  localparam int unsigned LifeW     = $clog2(Lives + 1);
  localparam int unsigned ToW       = $clog2(ToTicks + 1);

  // Packed control view {r1,r2,e1,e2,e3,e4,sel,replay} expected per state.
  localparam logic [7:0] OInit   = 8'b1100_0000;
  localparam logic [7:0] OSetup  = 8'b0010_0000;
  localparam logic [7:0] OUser   = 8'b0001_0000;
  localparam logic [7:0] OFpga   = 8'b0000_1000;
  localparam logic [7:0] OCheck  = 8'b0000_0100;
  localparam logic [7:0] ONext   = 8'b0100_0000;
  localparam logic [7:0] ORetry  = 8'b0000_0001;
  localparam logic [7:0] OResult = 8'b0000_0010;

  logic clock = 1'b0;
  logic reset, enter, tick, end_fpga, end_user, match;
  logic r1, r2, e1, e2, e3, e4, sel, replay, won;
  logic [RoundW-1:0] round;
  logic [LifeW-1:0]  lives_left;
  logic [ToW-1:0]    time_left;

  int n_vec = 0;
  int n_err = 0;

  game_ctrl_fsm_v2 #(
    .MAX_ROUNDS   (MaxRounds),
    .LIVES        (Lives),
    .TIMEOUT_TICKS(ToTicks)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enter     (enter),
    .tick      (tick),
    .end_fpga  (end_fpga),
    .end_user  (end_user),
    .match     (match),
    .r1        (r1),
    .r2        (r2),
    .e1        (e1),
    .e2        (e2),
    .e3        (e3),
    .e4        (e4),
    .sel       (sel),
    .replay    (replay),
    .won       (won),
    .round     (round),
    .lives_left(lives_left),
    .time_left (time_left)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, r1, r2, e1, e2, e3, e4, sel, replay}, {24'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int rnd, input int lv);
    check({tag, ".round"}, 32'(round), rnd);
    check({tag, ".lives"}, 32'(lives_left), lv);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press_enter();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // PLAY_FPGA -> PLAY_USER -> CHECK, leaving match to be driven in CHECK.
  task automatic fpga_then_user();
    end_fpga = 1'b1;
    step();
    end_fpga = 1'b0;
    end_user = 1'b1;
    step();
    end_user = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; tick = 1'b0;
    end_fpga = 1'b0; end_user = 1'b0; match = 1'b0;
    step(); step();
    chk_out("rst.out", OInit);
    chk_cnt("rst", 0, 2);
    check("rst.time", 32'(time_left), 3);
    check("rst.won", 32'(won), 0);

    // INIT lasts one cycle, then SETUP; held enter gives a single PLAY_FPGA entry.
    reset = 1'b0;
    step();
    chk_out("setup.out", OSetup);
    enter = 1'b1;
    step();
    chk_out("hold.fpga", OFpga);
    for (int i = 0; i < 9; i++) step();
    chk_out("hold.stay", OFpga);
    enter = 1'b0;
    step();
    press_enter();
    step();
    chk_out("repress.stay", OFpga);

    // Two clean rounds to a win.
    for (int r = 0; r < 2; r++) begin
      end_fpga = 1'b1;
      step();
      end_fpga = 1'b0;
      chk_out("win.user", OUser);
      check("win.time", 32'(time_left), 3);
      end_user = 1'b1;
      step();
      end_user = 1'b0;
      chk_out("win.check", OCheck);
      match = 1'b1;
      step();
      match = 1'b0;
      chk_out("win.next", ONext);
      chk_cnt("win.next", r, 2);
      step();
      if (r == 0) begin
        chk_out("win.fpga", OFpga);
        chk_cnt("win.fpga", 1, 2);
      end
    end
    chk_out("win.result", OResult);
    chk_cnt("win.result", 2, 2);
    check("win.won", 32'(won), 1);
    end_user = 1'b1; end_fpga = 1'b1; match = 1'b1;
    step();
    end_user = 1'b0; end_fpga = 1'b0; match = 1'b0;
    chk_out("win.hold", OResult);
    check("win.won.hold", 32'(won), 1);
    press_enter();
    chk_out("win.init", OInit);
    chk_cnt("win.init", 2, 2);
    step();
    chk_out("win.setup", OSetup);
    chk_cnt("win.setup", 0, 2);
    check("win.won.clr", 32'(won), 0);

    // Timeout: three ticks with no entry costs a life; round unchanged.
    press_enter();
    end_fpga = 1'b1;
    step();
    end_fpga = 1'b0;
    check("to.t3", 32'(time_left), 3);
    pulse_tick();
    check("to.t2", 32'(time_left), 2);
    pulse_tick();
    check("to.t1", 32'(time_left), 1);
    pulse_tick();
    check("to.t0", 32'(time_left), 0);
    chk_out("to.user", OUser);
    step();
    chk_out("to.retry", ORetry);
    step();
    chk_out("to.fpga", OFpga);
    chk_cnt("to.fpga", 0, 1);

    // end_user together with the third tick goes to CHECK, not RETRY.
    end_fpga = 1'b1;
    step();
    end_fpga = 1'b0;
    pulse_tick();
    pulse_tick();
    tick = 1'b1; end_user = 1'b1;
    step();
    tick = 1'b0; end_user = 1'b0;
    chk_out("tie.check", OCheck);
    check("tie.time", 32'(time_left), 1);
    match = 1'b1;
    step();
    match = 1'b0;
    step();
    chk_out("tie.fpga", OFpga);
    chk_cnt("tie.fpga", 1, 1);

    // Reset during PLAY_USER with timer=2, round=1.
    end_fpga = 1'b1;
    step();
    end_fpga = 1'b0;
    pulse_tick();
    pulse_tick();
    check("mid.time", 32'(time_left), 1);
    chk_cnt("mid.pre", 1, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("mid.init", OInit);
    chk_cnt("mid.init", 0, 2);
    check("mid.time3", 32'(time_left), 3);
    step();
    chk_out("mid.setup", OSetup);

    // Two mismatches exhaust both lives.
    press_enter();
    fpga_then_user();
    chk_out("mm1.check", OCheck);
    step();
    chk_out("mm1.retry", ORetry);
    step();
    chk_out("mm1.fpga", OFpga);
    chk_cnt("mm1.fpga", 0, 1);
    fpga_then_user();
    step();
    chk_out("mm2.retry", ORetry);
    step();
    chk_out("mm2.result", OResult);
    chk_cnt("mm2.result", 0, 0);
    check("mm2.won", 32'(won), 0);
    step();
    chk_out("mm2.hold", OResult);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm_v2.md
Name: game_ctrl_fsm_v2

Overview:
- Parametrised successor to the memory-game control FSM: sequences setup, FPGA sequence playback, user entry, check, next round and result.
- Adds internally generated timeout (tick-counted), a round counter with configurable win length, a lives/retry mechanism, and edge-detected enter.
- Drives the datapath enables/resets (r1, r2, e1–e4, sel) and exposes round/lives/outcome status to the display logic.

Parameters:
MAX_ROUNDS, 8, rounds to complete for a win (>=1)
LIVES, 3, failures allowed before loss (>=1)
TIMEOUT_TICKS, 5, tick pulses allowed in PLAY_USER before timeout (>=1)
ROUND_W, $clog2(MAX_ROUNDS+1), round counter width
LIFE_W, $clog2(LIVES+1), lives counter width
TO_W, $clog2(TIMEOUT_TICKS+1), timeout counter width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
enter  in  1  level button, internally edge-detected
tick  in  1  one-cycle time-base pulse (e.g. 1 Hz enable)
end_fpga  in  1  FPGA playback finished
end_user  in  1  user finished entering sequence
match  in  1  user sequence equals FPGA sequence (valid in CHECK)
r1, r2  out  1  datapath resets (full / per-round)
e1, e2, e3, e4  out  1  datapath enables (setup, user, FPGA, check)
sel  out  1  display select: result view
replay  out  1  high in RETRY: datapath replays same sequence, no regeneration
won  out  1  registered outcome, valid in RESULT
round  out  ROUND_W  completed rounds
lives_left  out  LIFE_W  remaining lives
time_left  out  TO_W  TIMEOUT_TICKS minus elapsed ticks

Behaviour:
- Reset (synchronous, active-high) dominates every cycle: state=INIT, round=0, lives_left=LIVES, timer=0, won=0, enter_q=0. Outputs then: r1=r2=1, all else 0, time_left=TIMEOUT_TICKS.
- enter_p = enter & ~enter_q; enter_q registered every cycle. Only enter_p advances states; holding enter never chains transitions.
- Outputs are Moore-decoded from state only. Per state: INIT r1,r2; SETUP e1; PLAY_FPGA e3; PLAY_USER e2; CHECK e4; NEXT_ROUND r2; RETRY replay; RESULT sel. All others 0.
- INIT: 1 cycle -> SETUP; reload round=0, lives_left=LIVES, won=0.
- SETUP: stays until enter_p -> PLAY_FPGA.
- PLAY_FPGA: stays until end_fpga -> PLAY_USER. Timer cleared on entry to PLAY_USER.
- PLAY_USER: timer += 1 on each tick. Exit rules:
  - end_user=1 -> CHECK (takes priority over expiry in the same cycle).
  - else timer==TIMEOUT_TICKS -> RETRY (timeout counts as a failure).
  - A tick arriving in the same cycle as the transition is ignored.
- CHECK: 1 cycle; match=1 -> NEXT_ROUND, else -> RETRY.
- NEXT_ROUND: 1 cycle; round <= round+1.
  - If round==MAX_ROUNDS-1 -> RESULT with won<=1.
  - Else -> PLAY_FPGA.
- RETRY: 1 cycle; lives_left <= lives_left-1.
  - If lives_left==1 -> RESULT with won<=0.
  - Else -> PLAY_FPGA; round unchanged.
- RESULT: holds sel, won, round, lives_left until enter_p -> INIT.
- Undefined encodings -> INIT next cycle.
- Counters never wrap: round <= MAX_ROUNDS, lives_left >= 0, timer saturates at TIMEOUT_TICKS.
- Reset mid-operation (any state): next cycle is INIT with all counters reloaded; no partial output pulse.
- end_fpga/end_user/match are ignored outside their consuming state.

Test Plan (MAX_ROUNDS=2, LIVES=2, TIMEOUT_TICKS=3):
- Reset, enter held high 10 cycles -> INIT 1 cycle (r1=r2=1), SETUP, one PLAY_FPGA entry only; enter released and re-pressed in PLAY_FPGA -> no effect.
- Two clean rounds (end_fpga, end_user, match=1 each) -> round 0->1->2, second NEXT_ROUND -> RESULT sel=1 won=1 lives_left=2; enter_p -> INIT.
- Round 1: no end_user, 3 ticks -> time_left 3->2->1->0, RETRY (replay=1 one cycle), lives_left=1, PLAY_FPGA with round still 0.
- Two mismatches (match=0 in CHECK twice) -> lives 2->1->0, RESULT won=0 round=0.
- end_user and third tick in the same cycle -> CHECK, not RETRY; lives_left unchanged.
- reset asserted during PLAY_USER with timer=2, round=1 -> next cycle INIT, round=0, lives_left=2, time_left=3.
